fp_div_normround: RTL and testbench
===================================

# fp_div_normround

Post-divider stage for the floating-point divide path. Consumes the raw mantissa quotient and remainder produced by the `divider` array, plus sign, exponent and special-case tags carried alongside it. Normalizes, rounds to nearest-even using the remainder as sticky information, detects exponent overflow and underflow, and emits a packed IEEE-style result. The stage is a 2-stage valid/ready pipeline.

## Interface
- QUOTIENTLEN, 16, quotient width; must equal the divider's DIVIDENDLEN; must be >= MANTLEN+3
- REMAINDERLEN, 8, remainder width; must equal the divider's DIVISORLEN
- EXPLEN, 5, exponent field width; bias = 2^(EXPLEN-1)-1
- MANTLEN, 10, stored fraction width
- clk  in  1  clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- quotient  in  QUOTIENTLEN  bit QUOTIENTLEN-1 has weight 2^0; value lies in (0.5, 2)
- remainder  in  REMAINDERLEN  divider remainder; nonzero means inexact below the quotient LSB
- in_sign  in  1  result sign (sign_a XOR sign_b)
- in_exp  in  EXPLEN+2  signed biased exponent: ea - eb + bias
- in_special  in  2  00 normal, 01 force zero, 10 force infinity, 11 force NaN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  1+EXPLEN+MANTLEN  {sign, exp, fraction}
- overflow, underflow, inexact  out  1 each  flags qualified by out_valid

## Operation
- Stage 1 (normalize):
  - If quotient[QUOTIENTLEN-1] is 1: the leading one is at that bit and the exponent is unchanged.
  - Otherwise: shift the quotient left by 1 and decrement the exponent.
  - Fraction = MANTLEN bits directly below the leading one.
  - guard = next bit below the fraction.
  - sticky = OR of all lower quotient bits OR (remainder != 0).
- Stage 2 (round and pack):
  - Increment the fraction when guard & (sticky | fraction LSB).
  - Fraction carry-out: fraction becomes 0 and the exponent increments.
  - inexact = guard | sticky.
  - Final exponent e >= 2^EXPLEN-1: result is signed infinity, overflow=1, inexact=1.
  - Final exponent e <= 0: result is signed zero (flush, no subnormals), underflow=1, inexact=1.
- Specials bypass all arithmetic, and all flags are 0 for them:
  - Zero → {in_sign, 0, 0}.
  - Infinity → {in_sign, all-ones, 0}.
  - NaN → {0, all-ones, 1 followed by zeros} (canonical quiet NaN).
- Exponent arithmetic is carried at EXPLEN+2 signed bits throughout; no wrap-around is permitted.

## Timing
- Latency: exactly 2 cycles from accepted input to out_valid, with no stalls.
- Throughput: 1 beat per cycle.
- Transfer happens on the rising clk edge when valid & ready.
- Handshake rules:
  - Each stage holds a valid bit.
  - A stage advances when its successor is empty or draining.
  - in_ready = !s1_valid | (!s2_valid | out_ready).
- With out_ready low, at most 2 beats are held. in_ready then drops in the same cycle the second beat lands.
- result, flags and out_valid stay stable while out_valid & !out_ready.
- Order is strictly preserved.
- Simultaneous accept and drain in the same cycle must not drop or duplicate a beat.
- On rst assertion, mid-operation or otherwise:
  - Both valid bits clear immediately and in-flight beats are discarded.
  - out_valid=0, result=0 and all flags 0.
  - in_ready=1 after reset.
- Inputs are sampled only on an accepted edge; values are don't-care otherwise.

## Structure
- Shared package `fp_div_pkg` holds:
  - the special-case enum (SPEC_NORMAL, SPEC_ZERO, SPEC_INF, SPEC_NAN);
  - a bias function of EXPLEN;
  - the canonical-NaN constant builder.
- The upstream unpack stage imports the same package.
- One sub-module, `fp_rne_round`: combinational round-to-nearest-even over {fraction, guard, sticky}, returning the rounded fraction, carry-out and inexact. It is instantiated in stage 2.
- Pipeline registers and handshake logic live in the top module.

## Test plan
All cases use defaults (half precision, bias 15).
- 1.5/1.0: quotient 0xC000, remainder 0, in_exp 15 → result 0x3E00, flags 0, out_valid 2 cycles after accept.
- 1/1.5: quotient 0x5555, remainder nonzero, in_exp 15 → normalize shift, result 0x3955, inexact=1.
- Round carry: quotient 0xFFFF, remainder 1, in_exp 15 → result 0x4000, inexact=1. Tie: quotient 0x8010, remainder 0 → no increment, result 0x3C00, inexact=1.
- Range:
  - quotient 0x8000, in_exp 31 → 0x7C00, overflow=1.
  - quotient 0x8000, in_exp 0, in_sign 1 → 0x8000, underflow=1.
  - in_special 11 → 0x7E00, flags 0.
- Backpressure: hold out_ready=0 and offer 3 beats back-to-back → 2 accepted, in_ready low. Raise out_ready → beats emerge in order, one per cycle, and the third is accepted.
- Reset mid-flight with 2 beats held → out_valid drops asynchronously, result 0. Released beats never appear.

Source files
------------

// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared special-case tags and field helpers for the fp divide path
package fp_div_pkg;
  typedef enum logic [1:0] {
    SPEC_NORMAL = 2'b00,
    SPEC_ZERO   = 2'b01,
    SPEC_INF    = 2'b10,
    SPEC_NAN    = 2'b11
  } spec_e;
  function automatic int exp_bias(input int explen);
    return (1 << (explen - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan_bits(input int explen, input int mantlen);
    return (((64'd1 << explen) - 64'd1) << mantlen) | (64'd1 << (mantlen - 1));
  endfunction
endpackage

// File: rtl/fp_div_normround_if.sv
// fp_div_normround_if: input beat and output result channels of the post-divider stage
interface fp_div_normround_if #(
  parameter int QUOTIENTLEN  = 16,
  parameter int REMAINDERLEN = 8,
  parameter int EXPLEN       = 5,
  parameter int MANTLEN      = 10
);
  logic                          in_valid;
  logic                          in_ready;
  logic [QUOTIENTLEN-1:0]        quotient;
  logic [REMAINDERLEN-1:0]       remainder;
  logic                          in_sign;
  logic signed [EXPLEN+1:0]      in_exp;
  logic [1:0]                    in_special;
  logic                          out_valid;
  logic                          out_ready;
  logic [EXPLEN+MANTLEN:0]       result;
  logic                          overflow;
  logic                          underflow;
  logic                          inexact;
  modport master (
    output in_valid, quotient, remainder, in_sign, in_exp, in_special, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );
  modport slave (
    input  in_valid, quotient, remainder, in_sign, in_exp, in_special, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_rne_round.sv
// fp_rne_round: round-to-nearest-even of a fraction given guard and sticky bits
module fp_rne_round #(
  parameter int MANTLEN = 10
) (
  input  logic [MANTLEN-1:0] frac,
  input  logic               guard,
  input  logic               sticky,
  output logic [MANTLEN-1:0] frac_r,
  output logic               carry,
  output logic               inexact
);
  always_comb begin
    {carry, frac_r} = {1'b0, frac} + (MANTLEN+1)'(guard & (sticky | frac[0]));
    inexact = guard | sticky;
  end
endmodule

// File: rtl/fp_div_normround.sv
// fp_div_normround: normalize, RNE-round and pack a divider quotient; 2-stage valid/ready pipe
module fp_div_normround
  import fp_div_pkg::*;
#(
  parameter int QUOTIENTLEN  = 16,
  parameter int REMAINDERLEN = 8,
  parameter int EXPLEN       = 5,
  parameter int MANTLEN      = 10
) (
  input logic clk,
  input logic rst,
  fp_div_normround_if.slave bus
);
  localparam int EW = EXPLEN + 2;
  localparam int RW = 1 + EXPLEN + MANTLEN;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXPLEN) - 1);
  logic s2_adv, in_ready, take, lead, load2;
  logic [QUOTIENTLEN-2:0] qn;
  logic s1_valid_d, s1_valid_q, s1_sign_d, s1_sign_q, s1_guard_d, s1_guard_q, s1_sticky_d, s1_sticky_q;
  logic signed [EW-1:0] s1_exp_d, s1_exp_q, e;
  spec_e s1_spec_d, s1_spec_q;
  logic [MANTLEN-1:0] s1_frac_d, s1_frac_q, frac_r;
  logic carry, rinx, norm, ovf, unf;
  logic [RW-1:0] res, res_d, res_q;
  logic s2_valid_d, s2_valid_q, ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q;
  always_comb begin
    s2_adv = !s2_valid_q | bus.out_ready;
    in_ready = !s1_valid_q | s2_adv;
    take = bus.in_valid & in_ready;
    lead = bus.quotient[QUOTIENTLEN-1];
    // qn drops the leading-one position; only bits below it matter
    qn = lead ? bus.quotient[QUOTIENTLEN-2:0] : {bus.quotient[QUOTIENTLEN-3:0], 1'b0};
    s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
    s1_sign_d = take ? bus.in_sign : s1_sign_q;
    s1_exp_d = take ? bus.in_exp - EW'(!lead) : s1_exp_q;
    s1_spec_d = take ? spec_e'(bus.in_special) : s1_spec_q;
    s1_frac_d = take ? qn[QUOTIENTLEN-2 -: MANTLEN] : s1_frac_q;
    s1_guard_d = take ? qn[QUOTIENTLEN-2-MANTLEN] : s1_guard_q;
    s1_sticky_d = take ? (|qn[QUOTIENTLEN-3-MANTLEN:0]) | (|bus.remainder) : s1_sticky_q;
  end
  fp_rne_round #(.MANTLEN(MANTLEN)) u_round (
    .frac(s1_frac_q), .guard(s1_guard_q), .sticky(s1_sticky_q),
    .frac_r(frac_r), .carry(carry), .inexact(rinx)
  );
  always_comb begin
    e = s1_exp_q + EW'(carry);
    norm = s1_spec_q == SPEC_NORMAL;
    ovf = e >= EMAX;
    unf = e[EW-1] | (e == '0);
    res = s1_spec_q == SPEC_NAN ? RW'(qnan_bits(EXPLEN, MANTLEN)) :
          (s1_spec_q == SPEC_INF) | (norm & ovf) ? {s1_sign_q, {EXPLEN{1'b1}}, {MANTLEN{1'b0}}} :
          (s1_spec_q == SPEC_ZERO) | unf ? {s1_sign_q, {(RW-1){1'b0}}} :
          {s1_sign_q, e[EXPLEN-1:0], frac_r};
    load2 = s2_adv & s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    res_d = load2 ? res : res_q;
    ovf_d = load2 ? norm & ovf : ovf_q;
    unf_d = load2 ? norm & !ovf & unf : unf_q;
    inx_d = load2 ? norm & (rinx | ovf | unf) : inx_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_exp_q <= '0;
      s1_spec_q <= SPEC_NORMAL;
      s1_frac_q <= '0;
      s1_guard_q <= 1'b0;
      s1_sticky_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q <= s1_exp_d;
      s1_spec_q <= s1_spec_d;
      s1_frac_q <= s1_frac_d;
      s1_guard_q <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s2_valid_q <= s2_valid_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.result = res_q;
  assign bus.overflow = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact = inx_q;
endmodule

// File: tb/tb_fp_div_normround.sv
// tb_fp_div_normround: directed vector table plus backpressure and reset sequences
module tb_fp_div_normround;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  fp_div_normround_if bus ();
  fp_div_normround dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [15:0] q;
    logic [7:0]  r;
    logic [6:0]  e;
    logic        s;
    logic [1:0]  sp;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [15:0] q, input logic [7:0] r, input logic [6:0] e, input logic s, input logic [1:0] sp);
    bus.quotient = q;
    bus.remainder = r;
    bus.in_exp = e;
    bus.in_sign = s;
    bus.in_special = sp;
    bus.in_valid = 1'b1;
  endtask
  initial begin
    v[0]  = '{"div_1p5",     16'hC000, 8'h00, 7'd15, 1'b0, 2'b00, 16'h3E00, 3'b000};
    v[1]  = '{"div_inv1p5",  16'h5555, 8'h2A, 7'd15, 1'b0, 2'b00, 16'h3955, 3'b001};
    v[2]  = '{"round_carry", 16'hFFFF, 8'h01, 7'd15, 1'b0, 2'b00, 16'h4000, 3'b001};
    v[3]  = '{"tie_even",    16'h8010, 8'h00, 7'd15, 1'b0, 2'b00, 16'h3C00, 3'b001};
    v[4]  = '{"tie_odd_up",  16'h8030, 8'h00, 7'd15, 1'b0, 2'b00, 16'h3C02, 3'b001};
    v[5]  = '{"overflow",    16'h8000, 8'h00, 7'd31, 1'b0, 2'b00, 16'h7C00, 3'b101};
    v[6]  = '{"underflow",   16'h8000, 8'h00, 7'd0,  1'b1, 2'b00, 16'h8000, 3'b011};
    v[7]  = '{"max_exp",     16'h8000, 8'h00, 7'd30, 1'b0, 2'b00, 16'h7800, 3'b000};
    v[8]  = '{"carry_ovf",   16'hFFF0, 8'h00, 7'd30, 1'b0, 2'b00, 16'h7C00, 3'b101};
    v[9]  = '{"carry_rescue",16'h7FFF, 8'h00, 7'd1,  1'b0, 2'b00, 16'h0400, 3'b001};
    v[10] = '{"neg_exp",     16'hC000, 8'h00, 7'h7B, 1'b0, 2'b00, 16'h0000, 3'b011};
    v[11] = '{"spec_nan",    16'h1234, 8'h05, 7'd40, 1'b1, 2'b11, 16'h7E00, 3'b000};
    v[12] = '{"spec_inf",    16'h8000, 8'h00, 7'd15, 1'b1, 2'b10, 16'hFC00, 3'b000};
    v[13] = '{"spec_zero",   16'hFFFF, 8'h01, 7'd50, 1'b1, 2'b01, 16'h8000, 3'b000};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(16'h0, 8'h0, 7'd0, 1'b0, 2'b00);
    bus.in_valid = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk) drive(v[i].q, v[i].r, v[i].e, v[i].s, v[i].sp);
      chk({v[i].name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk) #1 bus.in_valid = 1'b0;
      chk({v[i].name, "_lat1"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk) #1;
      chk({v[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
      chk({v[i].name, "_result"}, 32'(bus.result), 32'(v[i].res));
      chk({v[i].name, "_flags"}, 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(v[i].flg));
    end
    @(posedge clk) #1 chk("drained", 32'(bus.out_valid), 32'd0);
    // backpressure: A=0x3E00, B=0x3C00, C=0x4000 with out_ready low
    @(negedge clk) bus.out_ready = 1'b0;
    drive(16'hC000, 8'h0, 7'd15, 1'b0, 2'b00);
    @(negedge clk) drive(16'h8000, 8'h0, 7'd15, 1'b0, 2'b00);
    @(negedge clk) drive(16'h8000, 8'h0, 7'd16, 1'b0, 2'b00);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_a_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_still_full", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_a", 32'(bus.result), 32'h3E00);
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk) #1 bus.in_valid = 1'b0;
    chk("bp_b_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_b", 32'(bus.result), 32'h3C00);
    @(posedge clk) #1;
    chk("bp_c_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_c", 32'(bus.result), 32'h4000);
    @(posedge clk) #1 chk("bp_empty", 32'(bus.out_valid), 32'd0);
    // reset with two beats held
    @(negedge clk) bus.out_ready = 1'b0;
    drive(16'hC000, 8'h0, 7'd20, 1'b0, 2'b00);
    @(negedge clk) drive(16'h8000, 8'h0, 7'd21, 1'b1, 2'b00);
    @(negedge clk) bus.in_valid = 1'b0;
    chk("rf_held_valid", 32'(bus.out_valid), 32'd1);
    chk("rf_held_full", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rf_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rf_result", 32'(bus.result), 32'd0);
    chk("rf_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1 chk("rf_no_ghost", 32'(bus.out_valid), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
